// File: rtl/ula_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ula_operand_loader
//  Purpose  : Keys ALU operand A, operand B and a 3-bit opcode from the switch
//             bank in three successive enter presses, then holds them stable
//             with valid high while the ALU result is displayed.
//  Options  : ULA_LOADER_DEBOUNCE_EN - when defined, a debounce counter of
//             DEBOUNCE_CYCLES stable cycles filters the synchronized enter level.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] op,
  output logic       valid,
  output logic [1:0] stage,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'b00,
    S_LOAD_B  = 2'b01,
    S_LOAD_OP = 2'b10,
    S_SHOW    = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_enter_s1;
  logic       r_enter_s2;
  logic       r_clr_s1;
  logic       r_clr_s2;
  logic       r_enter_prev;
  logic       w_enter_lvl;
  logic       w_press;
  logic       w_clear;

  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_op;
  logic [7:0] r_cnt;
  logic [7:0] w_a_nxt;
  logic [7:0] w_b_nxt;
  logic [2:0] w_op_nxt;
  logic [7:0] w_cnt_nxt;

  // Two-flop synchronizers for both asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enter_s1 <= 1'b0;
      r_enter_s2 <= 1'b0;
      r_clr_s1   <= 1'b0;
      r_clr_s2   <= 1'b0;
    end else begin
      r_enter_s1 <= btn_enter;
      r_enter_s2 <= r_enter_s1;
      r_clr_s1   <= btn_clear;
      r_clr_s2   <= r_clr_s1;
    end
  end

`ifdef ULA_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_db_cnt;
  logic             r_db_lvl;

  // Accept a level change only after it has persisted DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_db_lvl <= 1'b0;
    end else if (r_enter_s2 != r_db_lvl) begin
      if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db_lvl <= r_enter_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  assign w_enter_lvl = r_db_lvl;
`else
  // No filtering in this build: the synchronized level is the conditioned
  // level and DEBOUNCE_CYCLES has no effect on behaviour.
  if (DEBOUNCE_CYCLES > 0) begin : g_enter_direct
    assign w_enter_lvl = r_enter_s2;
  end else begin : g_enter_direct_any
    assign w_enter_lvl = r_enter_s2;
  end
`endif

  // Remember the previous conditioned level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enter_prev <= 1'b0;
    end else begin
      r_enter_prev <= w_enter_lvl;
    end
  end

  assign w_press = w_enter_lvl & ~r_enter_prev;
  assign w_clear = r_clr_s2;

  // Next-state and field-load decode; clear overrides a coincident press
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    if (w_clear) begin
      w_state_nxt = S_LOAD_A;
      w_a_nxt     = 8'h00;
      w_b_nxt     = 8'h00;
      w_op_nxt    = 3'b000;
    end else if (w_press) begin
      case (r_state)
        S_LOAD_A: begin
          w_a_nxt     = sw;
          w_state_nxt = S_LOAD_B;
        end
        S_LOAD_B: begin
          w_b_nxt     = sw;
          w_state_nxt = S_LOAD_OP;
        end
        S_LOAD_OP: begin
          w_op_nxt    = sw[2:0];
          w_cnt_nxt   = r_cnt + 8'd1;
          w_state_nxt = S_SHOW;
        end
        default: begin
          w_state_nxt = S_LOAD_A;
        end
      endcase
    end
  end

  // State and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD_A;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_op    <= 3'b000;
      r_cnt   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign op       = r_op;
  assign op_count = r_cnt;
  assign stage    = r_state;
  assign valid    = (r_state == S_SHOW);

endmodule
`default_nettype wire

// File: tb/tb_ula_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_operand_loader
//  Purpose  : Directed self-checking bench for ula_operand_loader with an
//             expected-value queue filled from a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_operand_loader;

`ifdef ULA_LOADER_DEBOUNCE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [1:0] stage;
    logic       valid;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       valid;
  logic [1:0] stage;
  logic [7:0] op_count;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [2:0] m_op;
  logic [1:0] m_st;
  logic [7:0] m_cnt;

  ula_operand_loader #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .a(a), .b(b), .op(op), .valid(valid), .stage(stage), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.a = m_a; e.b = m_b; e.op = m_op; e.stage = m_st;
    e.valid = (m_st == 2'b11); e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      n_tests--;
      e = sb.pop_front();
      cmp({tag, "_a"},     a,        e.a);
      cmp({tag, "_b"},     b,        e.b);
      cmp({tag, "_op"},    op,       e.op);
      cmp({tag, "_stage"}, stage,    e.stage);
      cmp({tag, "_valid"}, valid,    e.valid);
      cmp({tag, "_cnt"},   op_count, e.cnt);
    end
  endtask

  task automatic model_press(input logic [7:0] v);
    case (m_st)
      2'b00: m_a = v;
      2'b01: m_b = v;
      2'b10: begin m_op = v[2:0]; m_cnt = m_cnt + 8'd1; end
      default: ;
    endcase
    m_st = m_st + 2'd1;
  endtask

  // Raw rise just after an edge; capture expected LAT edges later.
  task automatic press(input logic [7:0] v, input int hold, input bit chk, input string tag);
    @(posedge clk); #1;
    sw = v;
    btn_enter = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    if (chk) cmp({tag, "_early_stage"}, stage, m_st);
    @(posedge clk); #1;
    model_press(v);
    if (chk) begin
      push_model();
      check_out(tag);
    end
    repeat (hold - LAT - 1) @(posedge clk);
    #1 btn_enter = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    if (chk) cmp({tag, "_settled_stage"}, stage, m_st);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 3'b000; m_st = 2'b00; m_cnt = 8'h00;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sw = 8'h00; btn_enter = 1'b0; btn_clear = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 3'b000; m_st = 2'b00; m_cnt = 8'h00;

    // Reset state
    do_reset();
    @(negedge clk);
    push_model();
    check_out("reset");

    // Full load sequence and return to LOAD_A
    press(8'h3C, LAT + 1, 1'b1, "load_a");
    press(8'h05, LAT + 1, 1'b1, "load_b");
    press(8'hFC, LAT + 1, 1'b1, "load_op");
    cmp("show_op_value", op, 3'b100);
    cmp("show_count", op_count, 8'h01);
    press(8'h99, LAT + 1, 1'b1, "show_exit");

    // Held button: a single advance only
    press(8'hAA, 50, 1'b1, "held");
    cmp("held_a_value", a, 8'hAA);

    // Clear beats a coincident press in LOAD_OP
    press(8'h42, LAT + 1, 1'b1, "pre_clear_b");
    @(posedge clk); #1;
    sw = 8'hFF; btn_clear = 1'b1; btn_enter = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("clear_early_stage", stage, 2'b10);
    @(posedge clk); #1;
    m_a = 8'h00; m_b = 8'h00; m_op = 3'b000; m_st = 2'b00;
    push_model();
    check_out("clear_edge");
    repeat (20) @(posedge clk);
    #1 btn_clear = 1'b0; btn_enter = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    push_model();
    check_out("clear_settled");

`ifdef ULA_LOADER_DEBOUNCE_EN
    // Short glitch is filtered out
    @(posedge clk); #1;
    sw = 8'h5A; btn_enter = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_enter = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    push_model();
    check_out("glitch");
    // A 20-cycle pulse advances exactly once with full latency
    press(8'h5A, 20, 1'b1, "pulse20");
`endif

    // Reset mid-sequence discards partial load and count
    press(8'h77, LAT + 1, 1'b1, "pre_reset");
    do_reset();
    @(negedge clk);
    push_model();
    check_out("mid_reset");

    // 256 complete loads wrap op_count to zero
    for (int i = 0; i < 256; i++) begin
      press(8'(i),       LAT + 1, 1'b0, "wrap_a");
      press(~8'(i),      LAT + 1, 1'b0, "wrap_b");
      press(8'(i),       LAT + 1, (i == 254) || (i == 255), "wrap_op");
      press(8'h00,       LAT + 1, 1'b0, "wrap_show");
    end
    push_model();
    check_out("wrap_final");
    cmp("wrap_count_zero", op_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
